// File: rtl/itof_arbiter_pkg.sv
// Shared types and constants for the int-to-float converter arbiter.
// Optional statistics are enabled with ITOF_ARB_STATS_EN (see itof_arbiter.sv).
package itof_arbiter_pkg;
  localparam int CONV_W   = 32;
  localparam int N_DEF    = 2;
  localparam int TAGW_DEF = 5;
  localparam int IDW      = $clog2(N_DEF);

  // Default-width in-flight entry; the top re-declares it against its own N/TAGW.
  typedef struct packed {
    logic            v;
    logic [IDW-1:0]  id;
    logic [TAGW_DEF-1:0] tag;
  } pipe_t;

  function automatic int next_idx(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/itof_arbiter_rr_arbiter.sv
// N-input round-robin arbiter; search starts at ptr, ptr moves past each winner.
module rr_arbiter
  import itof_arbiter_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);
  logic [IDW-1:0] ptr;
  int j;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!gnt_any && req[j]) begin
        gnt_any  = 1'b1;
        gnt_idx  = IDW'(j);
        grant[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (gnt_any) ptr <= IDW'(next_idx(int'(gnt_idx), N));
  end
endmodule

// File: rtl/itof_arbiter.sv
// Shares one fixed-latency int-to-float pipe among N requesters, {id,tag} ride alongside.
// Define ITOF_ARB_STATS_EN to add stat_grants / stat_conflict counters.
module itof_arbiter
  import itof_arbiter_pkg::*;
#(
  parameter int N       = 2,
  parameter int TAGW    = 5,
  parameter int LATENCY = 3,
  parameter int MAX_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*CONV_W-1:0]    req_data,
  input  logic [N*TAGW-1:0]      req_tag,
  output logic [CONV_W-1:0]      conv_x,
  input  logic [CONV_W-1:0]      conv_y,
  output logic                   rsp_valid,
  output logic [$clog2(N)-1:0]   rsp_id,
  output logic [TAGW-1:0]        rsp_tag,
  output logic [CONV_W-1:0]      rsp_data
`ifdef ITOF_ARB_STATS_EN
  ,
  output logic [N*16-1:0]        stat_grants,
  output logic [15:0]            stat_conflict
`endif
);
  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic            v;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
  } entry_t;

  // pipe[0] is the issue register, pipe[1..LATENCY] track the converter stages
  entry_t               pipe [LATENCY+1];
  logic [N-1:0][CW-1:0] cnt;
  logic [N-1:0]         elig, cand, grant, dec;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_any;
  int                   gi;

  always_comb begin
    elig = '0;
    dec  = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = cnt[i] < CW'(MAX_OUT);
      dec[i]  = pipe[LATENCY].v && (pipe[LATENCY].id == IDW'(i));
    end
  end

  assign cand      = req_valid & elig & {N{~rst}};
  assign req_ready = grant;
  assign gi        = int'(gnt_idx);

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (cand),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_x <= '0;
      for (int s = 0; s <= LATENCY; s++) pipe[s] <= '0;
    end else begin
      conv_x  <= gnt_any ? req_data[gi*CONV_W +: CONV_W] : '0;
      pipe[0] <= gnt_any ? entry_t'{v: 1'b1, id: gnt_idx, tag: req_tag[gi*TAGW +: TAGW]} : '0;
      for (int s = 1; s <= LATENCY; s++) pipe[s] <= pipe[s-1];
    end
  end

  // A grant and a response for the same requester in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else for (int i = 0; i < N; i++) begin
      if (grant[i] && !dec[i])      cnt[i] <= cnt[i] + 1'b1;
      else if (dec[i] && !grant[i]) cnt[i] <= cnt[i] - 1'b1;
    end
  end

  assign rsp_valid = pipe[LATENCY].v;
  assign rsp_id    = pipe[LATENCY].id;
  assign rsp_tag   = pipe[LATENCY].tag;
  assign rsp_data  = conv_y;

`ifdef ITOF_ARB_STATS_EN
  logic [N-1:0][15:0] sg;
  assign stat_grants = sg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sg            <= '0;
      stat_conflict <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (grant[i] && sg[i] != 16'hFFFF) sg[i] <= sg[i] + 16'd1;
      if ($countones(cand) >= 2 && stat_conflict != 16'hFFFF)
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_itof_arbiter.sv
// Directed + random bench for itof_arbiter with a behavioural 3-stage converter.
module tb_itof_arbiter;
  localparam int N = 2, TAGW = 5, LAT = 3, MAXO = 2;

  logic            clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [N*32-1:0] req_data = '0;
  logic [N*TAGW-1:0] req_tag = '0;
  logic [31:0]     conv_x, conv_y, rsp_data;
  logic            rsp_valid;
  logic [0:0]      rsp_id;
  logic [TAGW-1:0] rsp_tag;
`ifdef ITOF_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_conflict;
`endif

  int total = 0, bad = 0;

  itof_arbiter #(.N(N), .TAGW(TAGW), .LATENCY(LAT), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .conv_x(conv_x), .conv_y(conv_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data)
`ifdef ITOF_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] itof(input logic [31:0] x);
    logic s; logic [31:0] m, rem, half; logic [24:0] q; int p, sh, e;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (~x + 32'd1) : x;
    p = 0;
    for (int k = 0; k < 32; k++) if (m[k]) p = k;
    e = 127 + p;
    if (p <= 23) q = 25'(m << (23 - p));
    else begin
      sh   = p - 23;
      q    = 25'(m >> sh);
      rem  = m & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 25'd1;
      if (q[24]) begin q = q >> 1; e++; end
    end
    return {s, e[7:0], q[22:0]};
  endfunction

  // Converter stand-in: exactly LAT register stages, no reset.
  logic [31:0] c1, c2, c3;
  always @(posedge clk) begin c1 <= itof(conv_x); c2 <= c1; c3 <= c2; end
  assign conv_y = c3;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: RR pointer, counters, and a 4-deep history of accepted ops.
  int ptr_m, er, jj, gcnt [N], cnt_m [N];
  bit hv [4]; int hid [4]; logic [TAGW-1:0] htag [4]; logic [31:0] hdata [4];
  logic [N-1:0] g;

  always @(negedge clk) begin
    if (rst) begin
      ptr_m = 0;
      for (int i = 0; i < N; i++) begin cnt_m[i] = 0; gcnt[i] = 0; end
      for (int s = 0; s < 4; s++) begin hv[s] = 0; hid[s] = 0; htag[s] = '0; hdata[s] = '0; end
      chk("rst_rsp_v", 32'(rsp_valid), 32'd0);
    end else begin
      er = 0;
      for (int k = 0; k < N; k++) begin
        jj = (ptr_m + k) % N;
        if (er == 0 && req_valid[jj] && cnt_m[jj] < MAXO) er = 1 << jj;
      end
      chk("ready_model", 32'(req_ready), 32'(er));
      chk("rsp_v", 32'(rsp_valid), 32'(hv[3]));
      chk("rsp_id", 32'(rsp_id), hv[3] ? 32'(hid[3]) : 32'd0);
      chk("rsp_tag", 32'(rsp_tag), hv[3] ? 32'(htag[3]) : 32'd0);
      if (hv[3]) chk("rsp_data", rsp_data, hdata[3]);
      for (int i = 0; i < N; i++) begin
        chk("cnt", 32'(dut.cnt[i]), 32'(cnt_m[i]));
        chk("cnt_max", 32'(dut.cnt[i] <= MAXO), 32'd1);
      end
      if (hv[3]) cnt_m[hid[3]]--;
      g = req_valid & req_ready;
      for (int s = 3; s > 0; s--) begin
        hv[s] = hv[s-1]; hid[s] = hid[s-1]; htag[s] = htag[s-1]; hdata[s] = hdata[s-1];
      end
      hv[0] = 0; hid[0] = 0; htag[0] = '0; hdata[0] = '0;
      for (int i = 0; i < N; i++) if (g[i]) begin
        cnt_m[i]++; gcnt[i]++;
        ptr_m = (i + 1) % N;
        hv[0] = 1; hid[0] = i;
        htag[0] = req_tag[i*TAGW +: TAGW];
        hdata[0] = itof(req_data[i*32 +: 32]);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [31:0] d0, input logic [TAGW-1:0] t0,
                       input logic [31:0] d1, input logic [TAGW-1:0] t1);
    req_valid = v;
    req_data  = {d1, d0};
    req_tag   = {t1, t0};
  endtask

  logic [1:0] cont_exp [10] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0};
  logic [1:0] lim_exp  [8]  = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0};

  initial begin
    // reset state, with requests pending so ready masking is visible
    drive(2'b11, 32'd1, 5'd1, 32'd2, 5'd2);
    step(2); #1;
    chk("rst_conv_x", conv_x, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    drive(2'b00, 0, 0, 0, 0);
    step(); rst = 1'b0;
    step();

    // single request, 1+LAT latency
    drive(2'b01, 32'h5, 5'd3, 0, 0); #1;
    chk("single_ready", 32'(req_ready), 32'd1);
    step(); drive(2'b00, 0, 0, 0, 0);
    chk("single_conv_x", conv_x, 32'h5);
    step(2); chk("single_early", 32'(rsp_valid), 32'd0);
    step();
    chk("single_v", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_tag", 32'(rsp_tag), 32'd3);
    chk("single_data", rsp_data, 32'h40A00000);
    step(4);

    // contention: ptr sits at 1 after the single grant to 0
    for (int c = 0; c < 10; c++) begin
      drive(2'b11, 32'(100 + c), 5'(c), 32'(200 + c), 5'(c + 16)); #1;
      chk("cont_ready", 32'(req_ready), 32'(cont_exp[c]));
      step();
    end
    drive(2'b00, 0, 0, 0, 0); step(8);

    // outstanding limit on requester 1
    for (int c = 0; c < 8; c++) begin
      drive(2'b10, 0, 0, 32'(-c), 5'(c)); #1;
      chk("lim_ready", 32'(req_ready), 32'(lim_exp[c]));
      step();
    end
    drive(2'b00, 0, 0, 0, 0); step(8);

    // negative / extreme operands
    drive(2'b01, 32'hFFFFFFFF, 5'd7, 0, 0); #1;
    chk("neg_ready0", 32'(req_ready), 32'd1);
    step(); drive(2'b01, 32'h80000000, 5'd9, 0, 0); #1;
    chk("neg_ready1", 32'(req_ready), 32'd1);
    step(); drive(2'b00, 0, 0, 0, 0);
    step(2);
    chk("neg_tag0", 32'(rsp_tag), 32'd7);
    chk("neg_data0", rsp_data, 32'hBF800000);
    step();
    chk("neg_tag1", 32'(rsp_tag), 32'd9);
    chk("neg_data1", rsp_data, 32'hCF000000);
    step(4);

    // reset with three ops in flight
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 32'(7 + c), 5'(c), 32'(9 + c), 5'(c + 4));
      step();
    end
    rst = 1'b1; #1;
    chk("mid_conv_x", conv_x, 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd0);
    chk("mid_ptr", 32'(dut.u_arb.ptr), 32'd0);
    chk("mid_cnt0", 32'(dut.cnt[0]), 32'd0);
    chk("mid_cnt1", 32'(dut.cnt[1]), 32'd0);
    step(); rst = 1'b0; drive(2'b00, 0, 0, 0, 0);
    step(6);
    drive(2'b10, 0, 0, 32'd100, 5'd21); #1;
    chk("post_ready", 32'(req_ready), 32'd2);
    step(); drive(2'b00, 0, 0, 0, 0);
    step(3);
    chk("post_v", 32'(rsp_valid), 32'd1);
    chk("post_id", 32'(rsp_id), 32'd1);
    chk("post_tag", 32'(rsp_tag), 32'd21);
    chk("post_data", rsp_data, 32'h42C80000);
    step(2);

    // random patterns, all checking in the reference model
    for (int c = 0; c < 10000; c++) begin
      drive(2'($urandom_range(0, 3)), $urandom, 5'($urandom), $urandom, 5'($urandom));
      step();
    end
    drive(2'b00, 0, 0, 0, 0); step(6);
`ifdef ITOF_ARB_STATS_EN
    chk("stat_g0", 32'(stat_grants[15:0]), 32'(gcnt[0] > 65535 ? 65535 : gcnt[0]));
    chk("stat_g1", 32'(stat_grants[31:16]), 32'(gcnt[1] > 65535 ? 65535 : gcnt[1]));
    chk("stat_conf_nz", 32'(stat_conflict != 16'd0), 32'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
